// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use bubbles, branch flush, memory-wait freeze.
// Latency: all hold/flush/forward outputs are combinational in the current cycle; counters update on the next edge.
// Backpressure: a pending memory access freezes F/D/E/M and bubbles W until mem_ready_m, overriding all else.
module hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_d,
  input  logic [ADDR_W-1:0] rs2_d,
  input  logic [ADDR_W-1:0] rs1_e,
  input  logic [ADDR_W-1:0] rs2_e,
  input  logic [ADDR_W-1:0] rd_e,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_e,
  input  logic              pc_src_e,
  input  logic              mem_req_m,
  input  logic              mem_ready_m,
  input  logic              clr_cnt,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  // First load bubble is issued from RUN, so the down-counter covers the remaining LOAD_LAT-1.
  localparam logic [2:0] LCNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  state_t           state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       lw_haz, mem_wait;
  logic       st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;

  // Forward selection: M beats W, register 0 never forwards.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      fwd_a_raw = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) fwd_a_raw = 2'b01;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      fwd_b_raw = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) fwd_b_raw = 2'b01;
  end

  assign lw_haz   = (result_src_e == 2'b01) && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign mem_wait = mem_req_m && !mem_ready_m;

  // Next-state and raw hold/flush decode; priority is mem_wait, then branch, then load-use.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_w = 1'b0;
    case (state_q)
      RUN, LOAD_STALL: begin
        if (mem_wait) begin
          st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1; fl_w = 1'b1;
          lcnt_d  = 3'd0;
          state_d = MEM_WAIT;
        end else if (pc_src_e) begin
          fl_d = 1'b1; fl_e = 1'b1;
          lcnt_d  = 3'd0;
          state_d = RUN;
        end else if (state_q == LOAD_STALL) begin
          st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
          if (lcnt_q == 3'd0) state_d = RUN;
          else                lcnt_d = lcnt_q - 3'd1;
        end else if (lw_haz) begin
          st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
          if (LOAD_LAT > 1) begin
            lcnt_d  = LCNT_INIT;
            state_d = LOAD_STALL;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready_m) begin
          state_d = RUN;
        end else begin
          st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1; fl_w = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        lcnt_d  = 3'd0;
      end
    endcase
  end

  // Outputs forced quiet while reset is held, independent of the other inputs.
  assign fwd_a_e = rst ? fwd_a_raw : 2'b00;
  assign fwd_b_e = rst ? fwd_b_raw : 2'b00;
  assign stall_f = rst & st_f;
  assign stall_d = rst & st_d;
  assign stall_e = rst & st_e;
  assign stall_m = rst & st_m;
  assign flush_d = rst & fl_d;
  assign flush_e = rst & fl_e;
  assign flush_w = rst & fl_w;
  assign busy    = (state_q != RUN);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f && !(&stall_cnt_q))             stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((flush_d || flush_e) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, bubble counter and performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      lcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based scoreboard sampled on the falling edge.
// Driver changes inputs 1 time unit after each rising edge and queues the expected outputs.
// Monitor pops one expectation per falling edge and compares outputs and (optionally) counters.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w;
  logic [1:0] result_src_e;
  logic       pc_src_e, mem_req_m, mem_ready_m, clr_cnt;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, busy;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] fa, fb;
    logic [3:0] st;
    logic [2:0] fl;
    logic       b;
    logic       cchk;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];

  hazard_ctrl #(.ADDR_W(5), .CNT_W(4), .LOAD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m),
    .mem_ready_m(mem_ready_m), .clr_cnt(clr_cnt),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] outs();
    return {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; result_src_e = 2'b00; pc_src_e = 0;
    mem_req_m = 0; mem_ready_m = 0; clr_cnt = 0;
  endtask

  task automatic set_load();
    result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next rising edge.
  task automatic cyc(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] st, input logic [2:0] fl, input logic b,
                     input logic cchk, input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.name = nm; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.b = b;
    e.cchk = cchk; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, "_outs"}, 32'(outs()), 32'({e.fa, e.fb, e.st, e.fl, e.b}));
        if (e.cchk) chk({e.name, "_cnts"}, 32'({stall_cnt, flush_cnt}), 32'({e.sc, e.fc}));
      end
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    // Busy inputs during reset must not leak to outputs.
    mem_req_m = 1; pc_src_e = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1; set_load();
    @(posedge clk); #1;
    cyc("rst_hold0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0);
    cyc("rst_hold1", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0);
    rst = 1'b1;
    idle();

    // Forwarding priority and register-0 suppression.
    rd_m = 5; rd_w = 5; rs1_e = 5; reg_write_m = 1; reg_write_w = 1; rs2_e = 3;
    cyc("fwd_m", 2'b10, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0);
    reg_write_m = 0;
    cyc("fwd_w", 2'b01, 2'b00, 4'b0000, 3'b000, 0, 0, 0, 0);
    rs1_e = 0;
    cyc("fwd_none", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0, 0);
    rd_m = 9; rd_w = 9; rs2_e = 9; reg_write_m = 1;
    cyc("fwd_b_m", 2'b00, 2'b10, 4'b0000, 3'b000, 0, 0, 0, 0);
    rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0; reg_write_w = 1;
    cyc("fwd_r0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0, 0);
    idle();

    // Load-use with three bubbles.
    set_load();
    cyc("lu1", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 1, 0, 0);
    cyc("lu2", 2'b00, 2'b00, 4'b1100, 3'b010, 1, 1, 1, 1);
    cyc("lu3", 2'b00, 2'b00, 4'b1100, 3'b010, 1, 1, 2, 2);
    idle();
    cyc("lu_done", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 3, 3);
    result_src_e = 2'b01; rd_e = 0; rs1_d = 0;
    cyc("lu_r0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 3, 3);
    idle(); result_src_e = 2'b10; rd_e = 7; rs2_d = 7;
    cyc("lu_notload", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 3, 3);
    idle(); clr_cnt = 1;
    cyc("clr_a", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 3, 3);
    clr_cnt = 0;

    // Branch aborts a load stall in its second bubble.
    set_load();
    cyc("br_lu1", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 1, 0, 0);
    pc_src_e = 1;
    cyc("br_abort", 2'b00, 2'b00, 4'b0000, 3'b110, 1, 1, 1, 1);
    idle();
    cyc("br_after0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 1, 2);
    cyc("br_after1", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 1, 2);

    // Memory wait: four frozen cycles, branch and load-use ignored meanwhile.
    mem_req_m = 1; mem_ready_m = 0;
    cyc("mw1", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 1, 1, 2);
    pc_src_e = 1;
    cyc("mw2", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 2, 2);
    pc_src_e = 0; set_load();
    cyc("mw3", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 3, 2);
    cyc("mw4", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 4, 2);
    idle(); mem_req_m = 1; mem_ready_m = 1; pc_src_e = 1;
    cyc("mw_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 5, 2);
    idle();
    cyc("mw_done", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 5, 2);

    // Memory wait preempts a load stall and discards its remaining bubbles.
    clr_cnt = 1;
    cyc("clr_b", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 5, 2);
    clr_cnt = 0; set_load();
    cyc("lm1", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 1, 0, 0);
    mem_req_m = 1;
    cyc("lm_mw", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 1, 1);
    mem_ready_m = 1;
    cyc("lm_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 2, 1);
    idle();
    cyc("lm_nobubble0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 2, 1);
    cyc("lm_nobubble1", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 2, 1);

    // Counter saturation at 15 with continuous load-use.
    clr_cnt = 1;
    cyc("clr_c", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 2, 1);
    clr_cnt = 0; set_load();
    for (int k = 1; k <= 21; k++)
      cyc("sat", 2'b00, 2'b00, 4'b1100, 3'b010, logic'(((k - 1) % 3) != 0), 1,
          4'((k - 1 > 15) ? 15 : k - 1), 4'((k - 1 > 15) ? 15 : k - 1));
    idle();
    cyc("sat_hold", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 15, 15);
    clr_cnt = 1;
    cyc("sat_clr", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 15, 15);
    clr_cnt = 0;
    cyc("sat_zero", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a memory wait.
    mem_req_m = 1; mem_ready_m = 0;
    cyc("rmw1", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 1, 0, 0);
    cyc("rmw2", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 1, 0);
    chk("pre_rst", 32'({stall_f, busy, stall_cnt}), 32'({1'b1, 1'b1, 4'd2}));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'd0);
    chk("async_rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    cyc("in_rst", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0);
    rst = 1'b1;
    cyc("post_rst_run", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 1, 0, 0);
    cyc("post_rst_mw", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 1, 1, 0);
    mem_ready_m = 1;
    cyc("post_rst_rdy", 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 2, 0);
    idle();
    cyc("final_idle", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 2, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counters.
REQ-003 Parameter LOAD_LAT, default 1, range 1..7, SHALL set the number of bubble cycles inserted per load-use hazard.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  ADDR_W  decode-stage source registers.
- rs1_e, rs2_e, rd_e  in  ADDR_W  execute-stage source and destination registers.
- rd_m, rd_w  in  ADDR_W  memory-stage and writeback-stage destination registers.
- reg_write_m, reg_write_w  in  1  register write enables in M and W.
- result_src_e  in  2  result select in E; 2'b01 means load.
- pc_src_e  in  1  taken branch or jump in E.
- mem_req_m  in  1  M stage has a memory access.
- mem_ready_m  in  1  memory has completed the access.
- clr_cnt  in  1  synchronous counter clear.
- fwd_a_e, fwd_b_e  out  2  forward select: 00 register file, 01 W, 10 M.
- stall_f, stall_d, stall_e, stall_m  out  1  per-stage hold.
- flush_d, flush_e, flush_w  out  1  per-stage bubble insert.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.
- busy  out  1  FSM is not in RUN.

Function
REQ-005 fwd_a_e SHALL be 10 when reg_write_m is 1, rd_m is not 0 and rd_m equals rs1_e; otherwise 01 when reg_write_w is 1, rd_w is not 0 and rd_w equals rs1_e; otherwise 00. The M stage SHALL take priority over W.
REQ-006 fwd_b_e SHALL follow the same rule as REQ-005, using rs2_e.
REQ-007 lw_haz SHALL be 1 when result_src_e is 01, rd_e is not 0, and rd_e equals rs1_d or rs2_d.
REQ-008 mem_wait SHALL be 1 when mem_req_m is 1 and mem_ready_m is 0.
REQ-009 The FSM states SHALL be RUN, LOAD_STALL and MEM_WAIT. A 3-bit down-counter lcnt SHALL be used in LOAD_STALL.
REQ-010 In RUN, mem_wait SHALL have the highest priority: it asserts stall_f, stall_d, stall_e, stall_m and flush_w in the same cycle, with all other flushes at 0, and the next state is MEM_WAIT.
REQ-011 In RUN with no mem_wait, pc_src_e SHALL assert flush_d and flush_e, hold all stalls at 0, and keep the state in RUN, even if lw_haz is 1.
REQ-012 In RUN with lw_haz and no pc_src_e, the block SHALL assert stall_f, stall_d and flush_e. If LOAD_LAT is greater than 1, the next state is LOAD_STALL with lcnt set to LOAD_LAT-2; otherwise the state stays in RUN.
REQ-013 In LOAD_STALL, the block SHALL assert stall_f, stall_d and flush_e. When lcnt is 0 the next state is RUN; otherwise lcnt decrements. A pc_src_e in this state SHALL abort the stall: flush_d and flush_e asserted, stalls at 0, next state RUN.
REQ-014 mem_wait in LOAD_STALL SHALL take priority as in REQ-010, and the remaining load bubbles are discarded.
REQ-015 In MEM_WAIT, the block SHALL assert stall_f, stall_d, stall_e, stall_m and flush_w, and ignore pc_src_e and lw_haz. When mem_ready_m is 1, all stalls and flushes SHALL be 0 in that same cycle and the next state is RUN.
REQ-016 busy SHALL be 1 exactly when the state is not RUN.
REQ-017 stall_cnt SHALL increment by 1 on each clock edge where stall_f is 1. flush_cnt SHALL increment by 1 on each edge where flush_d or flush_e is 1.
REQ-018 Both counters SHALL saturate at all-ones and never wrap.
REQ-019 clr_cnt SHALL zero both counters on the next edge and take priority over increment.
REQ-020 Register number 0 SHALL never produce a forward or a hazard.

Reset
REQ-021 While rst is 0, the state SHALL be RUN, lcnt 0, and both counters 0.
REQ-022 While rst is 0, all stall, flush, fwd and busy outputs SHALL be 0, regardless of the other inputs.
REQ-023 Reset asserted mid-stall SHALL abandon the stall immediately. The first cycle after release SHALL evaluate from RUN.

Verification
REQ-024 Forwarding: rd_m=rd_w=rs1_e=5, reg_write_m=reg_write_w=1 -> fwd_a_e=10. Then reg_write_m=0 -> fwd_a_e=01. Then rs1_e=0 -> fwd_a_e=00.
REQ-025 Load-use, LOAD_LAT=3: result_src_e=01, rd_e=rs2_d=7 -> stall_f, stall_d and flush_e high for exactly 3 cycles; stall_cnt=3; busy high for 2 cycles.
REQ-026 Branch during load stall, LOAD_LAT=3: pc_src_e=1 in the 2nd stall cycle -> flush_d=flush_e=1 and stall_f=0 that cycle; next state RUN; no further stall.
REQ-027 Memory wait: mem_req_m=1 with mem_ready_m=0 for 4 cycles, then 1 -> all four stalls and flush_w high for 4 cycles, low on the ready cycle; pc_src_e=1 during the wait causes no flush.
REQ-028 Counter saturation, CNT_W=4: hold lw_haz for 20 cycles -> stall_cnt stops at 15; clr_cnt=1 -> stall_cnt=0 on the next edge.
REQ-029 Reset: assert rst=0 asynchronously in the middle of MEM_WAIT -> all outputs 0 without waiting for a clock edge; busy=0; both counters 0.
